// File: rtl/fft_peak_sink.sv
// fft_peak_sink
//   Consumes fixed-length FFT output frames and reports the bin with the
//   largest L1 magnitude (|re|+|im|) once per frame.
//
// Ports
//   aclk, areset            clock, asynchronous active-high reset
//   cfg_log2n               log2 frame length, captured on beat 0 (clamped 3..MAX_LOG2N)
//   s_axis_data_*           sample stream {imag, real}; tlast is only checked
//   m_axis_peak_tdata       {index[15:0], 15'b0, magnitude[32:0]}
//   m_axis_peak_tuser       {tlast_unexpected, tlast_missing}
//   m_axis_peak_tvalid/ready result handshake
//   event_tlast_*           single-cycle pulses, one cycle after the offending beat
//   frame_count             results accepted downstream (wrapping)
module fft_peak_sink #(
  parameter int DATA_W    = 32,
  parameter int MAX_LOG2N = 12
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [3:0]            cfg_log2n,
  input  logic [2*DATA_W-1:0]   s_axis_data_tdata,
  input  logic                  s_axis_data_tvalid,
  output logic                  s_axis_data_tready,
  input  logic                  s_axis_data_tlast,
  output logic [63:0]           m_axis_peak_tdata,
  output logic [1:0]            m_axis_peak_tuser,
  output logic                  m_axis_peak_tvalid,
  input  logic                  m_axis_peak_tready,
  output logic                  event_tlast_unexpected,
  output logic                  event_tlast_missing,
  output logic [15:0]           frame_count
);

  localparam int CNT_W = MAX_LOG2N;
  localparam int MAG_W = DATA_W + 1;
  localparam int PAD_W = 64 - 16 - MAG_W;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    RESULT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   last_q, last_d;
  logic [MAG_W-1:0]   peak_mag_q, peak_mag_d;
  logic [CNT_W-1:0]   peak_idx_q, peak_idx_d;
  logic               sticky_unexp_q, sticky_unexp_d;
  logic               missing_q, missing_d;
  logic               tready_q, tready_d;
  logic               tvalid_q, tvalid_d;
  logic               ev_unexp_q, ev_unexp_d;
  logic               ev_miss_q, ev_miss_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic [3:0]         log2n_eff;
  logic [CNT_W-1:0]   last_new;
  logic [MAG_W-1:0]   mag;
  logic               data_xfer;
  logic               peak_xfer;
  logic               is_last;

  // Sign-extend by one bit before negating so that the most negative
  // input maps to +2^(DATA_W-1) without overflow.
  function automatic logic [MAG_W-1:0] abs_ext(input logic [DATA_W-1:0] v);
    logic [MAG_W-1:0] e;
    e = {v[DATA_W-1], v};
    return e[MAG_W-1] ? -e : e;
  endfunction

  assign mag       = abs_ext(s_axis_data_tdata[DATA_W-1:0]) +
                     abs_ext(s_axis_data_tdata[2*DATA_W-1:DATA_W]);
  assign data_xfer = s_axis_data_tvalid && tready_q;
  assign peak_xfer = tvalid_q && m_axis_peak_tready;
  assign is_last   = (cnt_q == last_q);

  // Last beat index for the clamped frame length: (2^log2n_eff) - 1.
  always_comb begin
    log2n_eff = cfg_log2n;
    if (cfg_log2n < 4'd3) begin
      log2n_eff = 4'd3;
    end else if (cfg_log2n > 4'(MAX_LOG2N)) begin
      log2n_eff = 4'(MAX_LOG2N);
    end
    last_new = '0;
    for (int unsigned i = 0; i < CNT_W; i++) begin
      last_new[i] = (i < {28'd0, log2n_eff});
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_d         = last_q;
    peak_mag_d     = peak_mag_q;
    peak_idx_d     = peak_idx_q;
    sticky_unexp_d = sticky_unexp_q;
    missing_d      = missing_q;
    tvalid_d       = tvalid_q;
    frame_cnt_d    = frame_cnt_q;
    ev_unexp_d     = 1'b0;
    ev_miss_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // Beat 0 always loads the peak; N >= 8 so it is never the last beat.
        if (data_xfer) begin
          last_d         = last_new;
          cnt_d          = CNT_W'(1);
          peak_mag_d     = mag;
          peak_idx_d     = '0;
          sticky_unexp_d = s_axis_data_tlast;
          ev_unexp_d     = s_axis_data_tlast;
          missing_d      = 1'b0;
          state_d        = COLLECT;
        end
      end
      COLLECT: begin
        if (data_xfer) begin
          if (mag > peak_mag_q) begin
            peak_mag_d = mag;
            peak_idx_d = cnt_q;
          end
          if (is_last) begin
            cnt_d     = '0;
            tvalid_d  = 1'b1;
            missing_d = !s_axis_data_tlast;
            ev_miss_d = !s_axis_data_tlast;
            state_d   = RESULT;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (s_axis_data_tlast) begin
              sticky_unexp_d = 1'b1;
              ev_unexp_d     = 1'b1;
            end
          end
        end
      end
      RESULT: begin
        if (peak_xfer) begin
          tvalid_d       = 1'b0;
          frame_cnt_d    = frame_cnt_q + 1'b1;
          sticky_unexp_d = 1'b0;
          missing_d      = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered ready follows the next state, so it is low during reset,
    // rises on the first edge after reset and drops with the final beat.
    tready_d = (state_d != RESULT);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      last_q         <= '0;
      peak_mag_q     <= '0;
      peak_idx_q     <= '0;
      sticky_unexp_q <= 1'b0;
      missing_q      <= 1'b0;
      tready_q       <= 1'b0;
      tvalid_q       <= 1'b0;
      ev_unexp_q     <= 1'b0;
      ev_miss_q      <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_q         <= last_d;
      peak_mag_q     <= peak_mag_d;
      peak_idx_q     <= peak_idx_d;
      sticky_unexp_q <= sticky_unexp_d;
      missing_q      <= missing_d;
      tready_q       <= tready_d;
      tvalid_q       <= tvalid_d;
      ev_unexp_q     <= ev_unexp_d;
      ev_miss_q      <= ev_miss_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  assign s_axis_data_tready     = tready_q;
  assign m_axis_peak_tvalid     = tvalid_q;
  assign m_axis_peak_tdata      = {{(16-CNT_W){1'b0}}, peak_idx_q, {PAD_W{1'b0}}, peak_mag_q};
  assign m_axis_peak_tuser      = {sticky_unexp_q, missing_q};
  assign event_tlast_unexpected = ev_unexp_q;
  assign event_tlast_missing    = ev_miss_q;
  assign frame_count            = frame_cnt_q;

endmodule

// File: tb/tb_fft_peak_sink.sv
module tb_fft_peak_sink;

  logic        aclk = 1'b0;
  logic        areset = 1'b0;
  logic [3:0]  cfg_log2n = '0;
  logic [63:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [63:0] m_tdata;
  logic [1:0]  m_tuser;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        ev_u, ev_m;
  logic [15:0] frame_count;

  fft_peak_sink #(.DATA_W(32), .MAX_LOG2N(12)) dut (
    .aclk                   (aclk),
    .areset                 (areset),
    .cfg_log2n              (cfg_log2n),
    .s_axis_data_tdata      (s_tdata),
    .s_axis_data_tvalid     (s_tvalid),
    .s_axis_data_tready     (s_tready),
    .s_axis_data_tlast      (s_tlast),
    .m_axis_peak_tdata      (m_tdata),
    .m_axis_peak_tuser      (m_tuser),
    .m_axis_peak_tvalid     (m_tvalid),
    .m_axis_peak_tready     (m_tready),
    .event_tlast_unexpected (ev_u),
    .event_tlast_missing    (ev_m),
    .frame_count            (frame_count)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int ev_u_cnt = 0;
  int ev_m_cnt = 0;
  int exp_fc = 0;

  longint frm_re   [4096];
  longint frm_im   [4096];
  bit     frm_last [4096];

  // Event pulses are counted on the falling edge; each one-cycle pulse is seen once.
  always @(negedge aclk) begin
    if (ev_u === 1'b1) ev_u_cnt++;
    if (ev_m === 1'b1) ev_m_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint rand_comp();
    case ($urandom_range(0, 3))
      0:       return -64'sd2147483648;
      1:       return 64'sd2147483647;
      2:       return longint'($urandom_range(0, 20)) - 10;
      default: return longint'(int'($urandom));
    endcase
  endfunction

  task automatic clear_frame(input int n);
    for (int i = 0; i < n; i++) begin
      frm_re[i] = 0;
      frm_im[i] = 0;
      frm_last[i] = (i == n - 1);
    end
  endtask

  task automatic fill_random(input int n, input bit rand_last);
    for (int i = 0; i < n; i++) begin
      frm_re[i] = rand_comp();
      frm_im[i] = rand_comp();
      frm_last[i] = (i == n - 1);
      if (rand_last && $urandom_range(0, 7) == 0) frm_last[i] = ~frm_last[i];
    end
  endtask

  // Reference: scan the whole frame with plain integer arithmetic.
  task automatic model(input int n, output logic [63:0] etdata, output logic [1:0] etuser,
                       output int eu, output int em);
    longint best, m;
    int     bidx;
    best = -1;
    bidx = 0;
    eu = 0;
    for (int i = 0; i < n; i++) begin
      m = (frm_re[i] < 0 ? -frm_re[i] : frm_re[i]) + (frm_im[i] < 0 ? -frm_im[i] : frm_im[i]);
      if (m > best) begin
        best = m;
        bidx = i;
      end
      if (i < n - 1 && frm_last[i]) eu++;
    end
    em = frm_last[n-1] ? 0 : 1;
    etdata = '0;
    etdata[63:48] = 16'(bidx);
    etdata[32:0]  = best[32:0];
    etuser = {(eu > 0) ? 1'b1 : 1'b0, (em > 0) ? 1'b1 : 1'b0};
  endtask

  // Called on a falling edge; returns on the falling edge after the transfer.
  task automatic send_beat(input int i);
    int guard;
    logic [63:0] re_v, im_v;
    guard = 0;
    re_v = 64'(frm_re[i]);
    im_v = 64'(frm_im[i]);
    s_tdata  = {im_v[31:0], re_v[31:0]};
    s_tlast  = frm_last[i];
    s_tvalid = 1'b1;
    while (s_tready !== 1'b1 && guard < 100) begin
      @(negedge aclk);
      guard++;
    end
    if (guard >= 100) check("tready_timeout", {63'd0, s_tready}, 64'd1);
    @(negedge aclk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic release_result(input int hold, input logic [63:0] etdata, input logic [1:0] etuser);
    m_tready = 1'b0;
    for (int c = 0; c < hold; c++) begin
      @(negedge aclk);
      check("hold_tvalid", {63'd0, m_tvalid}, 64'd1);
      check("hold_tdata", m_tdata, etdata);
      check("hold_tuser", {62'd0, m_tuser}, {62'd0, etuser});
      check("hold_s_tready", {63'd0, s_tready}, 64'd0);
      check("hold_frame_count", {48'd0, frame_count}, 64'(exp_fc));
    end
    m_tready = 1'b1;
    @(negedge aclk);
    m_tready = 1'b0;
    exp_fc++;
    check("frame_count", {48'd0, frame_count}, 64'(exp_fc & 16'hffff));
    check("tvalid_cleared", {63'd0, m_tvalid}, 64'd0);
    check("s_tready_after_result", {63'd0, s_tready}, 64'd1);
  endtask

  task automatic run_frame(input int n, input logic [3:0] cfg, input int max_gap,
                           input bit scramble, input int hold);
    logic [63:0] etdata;
    logic [1:0]  etuser;
    int eu, em, u0, m0;
    u0 = ev_u_cnt;
    m0 = ev_m_cnt;
    cfg_log2n = cfg;
    for (int i = 0; i < n; i++) begin
      if (max_gap > 0 && $urandom_range(0, 1) == 1) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(1, max_gap)) @(negedge aclk);
      end
      if (i == n - 1) check("tvalid_early", {63'd0, m_tvalid}, 64'd0);
      send_beat(i);
      if (scramble && i == 0) cfg_log2n = 4'($urandom_range(0, 15));
    end
    model(n, etdata, etuser, eu, em);
    check("tvalid_after_last", {63'd0, m_tvalid}, 64'd1);
    check("s_tready_pending", {63'd0, s_tready}, 64'd0);
    check("result_tdata", m_tdata, etdata);
    check("result_tuser", {62'd0, m_tuser}, {62'd0, etuser});
    if (hold >= 0) begin
      release_result(hold, etdata, etuser);
      check("event_unexpected_count", 64'(ev_u_cnt - u0), 64'(eu));
      check("event_missing_count", 64'(ev_m_cnt - m0), 64'(em));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_tready"}, {63'd0, s_tready}, 64'd0);
    check({tag, "_m_tvalid"}, {63'd0, m_tvalid}, 64'd0);
    check({tag, "_m_tdata"}, m_tdata, 64'd0);
    check({tag, "_m_tuser"}, {62'd0, m_tuser}, 64'd0);
    check({tag, "_events"}, {62'd0, ev_u, ev_m}, 64'd0);
    check({tag, "_frame_count"}, {48'd0, frame_count}, 64'd0);
  endtask

  task automatic do_reset(input string tag);
    #2 areset = 1'b1;
    #1 check_reset_outputs(tag);
    @(negedge aclk);
    areset = 1'b0;
    exp_fc = 0;
    check({tag, "_tready_before_edge"}, {63'd0, s_tready}, 64'd0);
    @(negedge aclk);
    check({tag, "_tready_after_edge"}, {63'd0, s_tready}, 64'd1);
  endtask

  initial begin
    int n;
    // Power-on reset
    #1 areset = 1'b1;
    #2 check_reset_outputs("por");
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    check("por_tready_before_edge", {63'd0, s_tready}, 64'd0);
    @(negedge aclk);
    check("por_tready_after_edge", {63'd0, s_tready}, 64'd1);

    // Ramp 0..7: peak at the last beat
    clear_frame(8);
    for (int i = 0; i < 8; i++) frm_re[i] = i;
    run_frame(8, 4'd3, 0, 1'b0, 0);

    // Equal peaks at beats 2 and 5, tlast early on beat 3 and missing on beat 7
    clear_frame(8);
    frm_re[2] = 3; frm_im[2] = -4;
    frm_re[5] = 3; frm_im[5] = -4;
    frm_last[7] = 1'b0;
    frm_last[3] = 1'b1;
    run_frame(8, 4'd3, 0, 1'b0, 0);

    // 512 beats, most negative real component, held result for 20 cycles
    clear_frame(512);
    frm_re[100] = -64'sd2147483648;
    frm_im[100] = 5;
    run_frame(512, 4'd9, 0, 1'b0, 20);

    // Full-scale magnitude 2^32 and a tie after a smaller beat 0
    clear_frame(8);
    frm_re[0] = 1;
    frm_re[3] = -64'sd2147483648; frm_im[3] = -64'sd2147483648;
    frm_re[6] = -64'sd2147483648; frm_im[6] = -64'sd2147483648;
    run_frame(8, 4'd3, 0, 1'b0, 0);

    // All-equal magnitudes: beat 0 must win
    clear_frame(8);
    for (int i = 0; i < 8; i++) begin
      frm_re[i] = (i % 2 == 0) ? -5 : 0;
      frm_im[i] = (i % 2 == 0) ? 0 : 5;
    end
    run_frame(8, 4'd3, 0, 1'b0, 1);

    // Two 16-beat frames, each run with random gaps and gap-free
    for (int f = 0; f < 2; f++) begin
      fill_random(16, 1'b0);
      run_frame(16, 4'd4, 4, 1'b0, 0);
      run_frame(16, 4'd4, 0, 1'b0, 0);
    end

    // Clamping: low config gives 8 beats, high config gives 4096 beats
    fill_random(8, 1'b0);
    run_frame(8, 4'd0, 0, 1'b1, 0);
    fill_random(4096, 1'b0);
    run_frame(4096, 4'd15, 0, 1'b1, 0);

    // Random frames: lengths, data, tlast placement, gaps, config noise, hold
    for (int f = 0; f < 8; f++) begin
      n = 1 << $urandom_range(3, 6);
      fill_random(n, 1'b1);
      run_frame(n, 4'($clog2(n)), 3, 1'b1, int'($urandom_range(0, 3)));
    end

    // Reset after beat 4 of 8, then a complete frame
    clear_frame(8);
    for (int i = 0; i < 8; i++) frm_re[i] = 100 + i;
    cfg_log2n = 4'd3;
    for (int i = 0; i < 5; i++) send_beat(i);
    do_reset("rst_midframe");
    clear_frame(8);
    frm_im[4] = -9;
    run_frame(8, 4'd3, 0, 1'b0, 0);

    // Reset with a result pending, then a complete frame
    fill_random(8, 1'b1);
    run_frame(8, 4'd3, 0, 1'b0, -1);
    do_reset("rst_pending");
    fill_random(8, 1'b0);
    run_frame(8, 4'd3, 1, 1'b0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
